// File: rtl/imm_decode_ctrl_if.sv
// Bus bundle between fetch, the shared immediate generator and execute.
// The slave side belongs to the decode controller; the master side is the surrounding environment.
interface imm_decode_ctrl_if;
  // Valid/ready: a transfer happens on a rising edge where valid && ready. The producer
  // holds valid and payload steady until that edge. Ready may depend combinationally on
  // the downstream ready.
  logic [31:0] instr_in;
  logic        instr_valid_in;
  logic        instr_ready_out;
  logic        flush_in;
  logic [24:0] gen_instr_out;
  logic [2:0]  gen_imm_type_out;
  logic [31:0] gen_imm_in;
  logic        dec_valid_out;
  logic        dec_ready_in;
  logic [31:0] dec_instr_out;
  logic [31:0] dec_imm_out;
  logic [2:0]  dec_imm_type_out;
  logic        dec_illegal_out;
  logic [31:0] issue_count_out;

  modport slave (
    input  instr_in, instr_valid_in, flush_in, gen_imm_in, dec_ready_in,
    output instr_ready_out, gen_instr_out, gen_imm_type_out, dec_valid_out,
           dec_instr_out, dec_imm_out, dec_imm_type_out, dec_illegal_out, issue_count_out
  );

  modport master (
    output instr_in, instr_valid_in, flush_in, gen_imm_in, dec_ready_in,
    input  instr_ready_out, gen_instr_out, gen_imm_type_out, dec_valid_out,
           dec_instr_out, dec_imm_out, dec_imm_type_out, dec_illegal_out, issue_count_out
  );
endinterface

// File: rtl/imm_decode_ctrl.sv
// Two-stage RV32I decode controller: classifies the opcode into an immediate type in
// stage 1, captures the shared generator's immediate in stage 2, with backpressure and flush.
module imm_decode_ctrl (
  input logic              clk_in,
  input logic              rst_n_in,
  imm_decode_ctrl_if.slave bus
);
  localparam logic [2:0] TYPE_R = 3'b000;
  localparam logic [2:0] TYPE_I = 3'b001;
  localparam logic [2:0] TYPE_S = 3'b010;
  localparam logic [2:0] TYPE_B = 3'b011;
  localparam logic [2:0] TYPE_U = 3'b100;
  localparam logic [2:0] TYPE_J = 3'b101;

  logic [2:0]  w_type;
  logic        w_illegal;
  logic        w_s2_load;
  logic        w_instr_ready;
  logic        w_accept;
  logic        w_advance;
  logic        w_handshake;

  logic        r_v1;
  logic        r_v2;
  logic [31:0] r_s1_instr;
  logic [2:0]  r_s1_type;
  logic        r_s1_illegal;
  logic [31:0] r_s2_instr;
  logic [31:0] r_s2_imm;
  logic [2:0]  r_s2_type;
  logic        r_s2_illegal;
  logic [31:0] r_issue_count;

  // Every legal opcode ends in 2'b11, so a bad low pair lands in the default arm.
  always_comb begin
    w_type    = TYPE_I;
    w_illegal = 1'b0;
    case (bus.instr_in[6:0])
      7'b0110011:                                           w_type = TYPE_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
      7'b0001111:                                           w_type = TYPE_I;
      7'b0100011:                                           w_type = TYPE_S;
      7'b1100011:                                           w_type = TYPE_B;
      7'b0110111, 7'b0010111:                               w_type = TYPE_U;
      7'b1101111:                                           w_type = TYPE_J;
      default:                                              w_illegal = 1'b1;
    endcase
  end

  assign w_s2_load     = !r_v2 || bus.dec_ready_in;
  assign w_instr_ready = !r_v1 || w_s2_load;
  assign w_accept      = bus.instr_valid_in && w_instr_ready && !bus.flush_in;
  assign w_advance     = r_v1 && w_s2_load && !bus.flush_in;
  assign w_handshake   = r_v2 && bus.dec_ready_in && !bus.flush_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else if (bus.flush_in) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (w_accept)       r_v1 <= 1'b1;
      else if (w_advance) r_v1 <= 1'b0;
      if (w_s2_load)      r_v2 <= r_v1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_s1_instr   <= '0;
      r_s1_type    <= TYPE_R;
      r_s1_illegal <= 1'b0;
      r_s2_instr   <= '0;
      r_s2_imm     <= '0;
      r_s2_type    <= TYPE_R;
      r_s2_illegal <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_instr   <= bus.instr_in;
        r_s1_type    <= w_type;
        r_s1_illegal <= w_illegal;
      end
      // Stage 2 only loads on an advance, which keeps dec_* frozen while stalled.
      if (w_advance) begin
        r_s2_instr   <= r_s1_instr;
        r_s2_imm     <= bus.gen_imm_in;
        r_s2_type    <= r_s1_type;
        r_s2_illegal <= r_s1_illegal;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)        r_issue_count <= '0;
    else if (w_handshake) r_issue_count <= r_issue_count + 32'd1;
  end

  assign bus.instr_ready_out  = w_instr_ready;
  assign bus.gen_instr_out    = r_s1_instr[31:7];
  assign bus.gen_imm_type_out = r_s1_type;
  assign bus.dec_valid_out    = r_v2;
  assign bus.dec_instr_out    = r_s2_instr;
  assign bus.dec_imm_out      = r_s2_imm;
  assign bus.dec_imm_type_out = r_s2_type;
  assign bus.dec_illegal_out  = r_s2_illegal;
  assign bus.issue_count_out  = r_issue_count;
endmodule
